// File: rtl/bit_population_counter.sv
// Parametrised ones/zeros population counter with an internal shift register,
// early termination on an empty operand, abort, and a start/rdy/done handshake.
module bit_population_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             rdy_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TEST  = 3'd1,
    S_SHIFT = 3'd2,
    S_ACC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             ebit_q, ebit_d;
  logic [CNT_W-1:0] count_q, count_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      ebit_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      ebit_q  <= ebit_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath control; abort wins in every busy state
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    ebit_d  = ebit_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          sreg_d  = mode_i ? ~data_in_i : data_in_i;
          count_d = '0;
          ebit_d  = 1'b0;
          state_d = S_TEST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TEST: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (sreg_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          ebit_d  = sreg_q[0];
          sreg_d  = sreg_q >> 1'b1;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          if (ebit_q) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            count_d = count_q;
          end
          state_d = S_TEST;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode; unused encodings look idle
  always_comb begin
    rdy_o  = 1'b1;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy_o  = 1'b1;
        busy_o = 1'b0;
      end
      S_TEST, S_SHIFT, S_ACC: begin
        rdy_o  = 1'b0;
        busy_o = 1'b1;
      end
      S_DONE: begin
        rdy_o  = 1'b0;
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        rdy_o  = 1'b1;
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_bit_population_counter.sv
// Directed-vector bench for bit_population_counter at WIDTH=8.
module tb_bit_population_counter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_b;
  logic             start_i;
  logic             abort_i;
  logic             mode_i;
  logic [WIDTH-1:0] data_in_i;
  logic             rdy_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] count_o;

  int n_checks;
  int n_bad;

  bit_population_counter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .mode_i    (mode_i),
    .data_in_i (data_in_i),
    .rdy_o     (rdy_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and measure cycles until done; optionally poke start mid-run
  task automatic run_op(input string tag, input logic [7:0] d, input logic m,
                        input int exp_cnt, input int exp_lat, input bit inject);
    int cyc;
    data_in_i = d;
    mode_i    = m;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    cyc = 1;
    while (!done_o && cyc < 200) begin
      if (inject && cyc == 3) begin
        start_i   = 1'b1;
        data_in_i = 8'hFF;
        mode_i    = 1'b0;
      end else begin
        start_i   = 1'b0;
      end
      tick();
      cyc++;
    end
    start_i = 1'b0;
    check_eq({tag, "_lat"}, cyc, exp_lat);
    check_eq({tag, "_cnt"}, {28'd0, count_o}, exp_cnt);
    tick();
    check_eq({tag, "_rdy"}, {31'd0, rdy_o}, 32'd1);
    check_eq({tag, "_hold"}, {28'd0, count_o}, exp_cnt);
  endtask

  initial begin
    int n_done;
    int done_at [3];
    n_checks  = 0;
    n_bad     = 0;
    rst_b     = 1'b0;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    mode_i    = 1'b0;
    data_in_i = 8'h00;
    #12;
    check_eq("rst_rdy", {31'd0, rdy_o}, 32'd1);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_cnt", {28'd0, count_o}, 32'd0);
    rst_b = 1'b1;
    tick();

    run_op("b5_ones", 8'hB5, 1'b0, 5, 26, 1'b0);
    run_op("b5_zeros", 8'hB5, 1'b1, 3, 23, 1'b0);
    run_op("ff_zeros", 8'hFF, 1'b1, 0, 2, 1'b0);
    run_op("ff_ones", 8'hFF, 1'b0, 8, 26, 1'b0);
    run_op("01_ones", 8'h01, 1'b0, 1, 5, 1'b0);
    run_op("busy_start", 8'hB5, 1'b0, 5, 26, 1'b1);

    // start held high: three operations of 0x01, done every 6 cycles
    data_in_i = 8'h01;
    mode_i    = 1'b0;
    start_i   = 1'b1;
    n_done    = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done_o) begin
        if (n_done < 3) done_at[n_done] = c;
        n_done++;
        if (n_done == 3) start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check_eq("held_ndone", n_done, 3);
    check_eq("held_d0", done_at[0], 5);
    check_eq("held_d1", done_at[1], 11);
    check_eq("held_d2", done_at[2], 17);
    check_eq("held_cnt", {28'd0, count_o}, 32'd1);
    check_eq("held_idle", {31'd0, rdy_o}, 32'd1);

    // abort during S_SHIFT of 0xF0
    data_in_i = 8'hF0;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    tick();
    abort_i   = 1'b1;
    tick();
    abort_i   = 1'b0;
    check_eq("abort_rdy", {31'd0, rdy_o}, 32'd1);
    check_eq("abort_done", {31'd0, done_o}, 32'd0);
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done_o || busy_o) n_done++;
    end
    check_eq("abort_quiet", n_done, 0);

    // start and abort together in idle
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    check_eq("sa_busy", {31'd0, busy_o}, 32'd0);
    check_eq("sa_rdy", {31'd0, rdy_o}, 32'd1);
    start_i = 1'b0;
    abort_i = 1'b0;

    // asynchronous reset mid-operation
    data_in_i = 8'hFF;
    mode_i    = 1'b0;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    check_eq("pre_rst_cnt", {28'd0, count_o}, 32'd2);
    #2;
    rst_b = 1'b0;
    #1;
    check_eq("mid_rst_rdy", {31'd0, rdy_o}, 32'd1);
    check_eq("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done_o}, 32'd0);
    check_eq("mid_rst_cnt", {28'd0, count_o}, 32'd0);
    #3;
    rst_b = 1'b1;
    tick();
    run_op("post_rst", 8'hB5, 1'b0, 5, 26, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_population_counter.md
Name: bit_population_counter

Overview:
Parametrised ones/zeros population counter with an integrated datapath and a start/rdy/done handshake. It is the generalised successor to the fixed-width count-ones controller. It adds the shift register and counter inside the block, a WIDTH parameter, a count-zeros mode, an abort input, and early termination when no set bits remain. It sits beside the other datapath/controller exercise blocks and is driven by a simple host sequencer.

Parameters:
WIDTH, 8, operand width in bits (>=1)
CNT_W, $clog2(WIDTH+1), count width; always holds WIDTH without overflow

Ports:
clk  input  1  clock, rising edge
rst_b  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in S_IDLE
abort  input  1  cancel operation in progress; priority over start
mode  input  1  0 = count ones, 1 = count zeros (operand inverted at load)
data_in  input  WIDTH  operand; sampled on start acceptance only
rdy  output  1  high in S_IDLE (ready to accept start)
busy  output  1  high in any state other than S_IDLE
done  output  1  one-cycle pulse in S_DONE
count  output  CNT_W  result register; valid when done=1, held until next accepted start

Behaviour:
- Reset (async, rst_b=0): state=S_IDLE, sreg=0, ebit=0, count=0; rdy=1, busy=0, done=0.
- Internal registers: sreg[WIDTH], ebit[1], count[CNT_W].
- Outputs are Moore: rdy=(state==S_IDLE), busy=!rdy, done=(state==S_DONE).
- S_IDLE:
  - If start=1 and abort=0: sreg<=mode ? ~data_in : data_in; count<=0; ebit<=0; next S_TEST.
  - Otherwise stay in S_IDLE; count holds.
- S_TEST: if sreg==0, next S_DONE (early termination); else next S_SHIFT.
- S_SHIFT: ebit<=sreg[0]; sreg<=sreg>>1 (zero fill); next S_ACC.
- S_ACC: if ebit=1, count<=count+1; next S_TEST.
- S_DONE: done=1 for exactly one cycle; next S_IDLE. count is unchanged.
- Latency:
  - Let k be the index of the highest set bit of the loaded sreg.
  - Non-idle cycles after the accepting edge = 3k+5. done is high in the last of these.
  - Loaded sreg==0 takes 2 cycles (S_TEST, S_DONE).
- Arithmetic: count increments at most WIDTH times, so CNT_W guarantees no wrap.
- start while busy: ignored; no queuing; data_in not sampled.
- abort=1 in any non-idle state: next state S_IDLE, done not asserted. count keeps its partial value and is undefined as a result.
- abort=1 in S_IDLE: start is not accepted that cycle.
- abort and the S_DONE transition in the same cycle: done still pulses (S_DONE already entered); next state S_IDLE either way.
- start held high continuously: a new operation is accepted in every S_IDLE cycle. Back-to-back operations have one S_IDLE cycle between done and the next S_TEST.
- Illegal/unused state encoding: next state S_IDLE, all outputs at idle values.
- rst_b asserted mid-operation: immediate return to reset values; no done.
- WIDTH=1 is legal: maximum latency 5 cycles.

Test Plan:
1. WIDTH=8, mode=0, data_in=0xB5, start one cycle -> busy next cycle; done on 26th cycle after acceptance; count=5; rdy back the following cycle.
2. mode=1, data_in=0xB5 (inverted 0x4A) -> count=3, done on 23rd cycle. Then mode=1, data_in=0xFF -> count=0, done on 2nd cycle.
3. mode=0, data_in=0xFF -> count=8 (no wrap, CNT_W=4), done on 26th cycle. Then data_in=0x01 -> count=1, done on 5th cycle.
4. Start pulsed again while busy with different data_in -> ignored; result matches the first operand. start held high for three operations -> exactly three done pulses, each separated by one rdy cycle.
5. abort=1 during S_SHIFT of a 0xF0 operation -> S_IDLE next cycle, no done, rdy=1. start and abort high together in S_IDLE -> not accepted, busy stays 0.
6. rst_b pulsed low mid-operation (asynchronous to clk) -> rdy=1, busy=0, done=0, count=0 immediately. A new start after release produces a correct result.
